// File: rtl/max_pool_1.sv
// max_pool_1: 2x2 stride-2 signed max pooling of a CHANNEL_NUM-channel raster pixel stream.
// Define MAX_POOL_1_ADDR_CHECK_EN to build the sticky input-address consistency check (addr_err).
module max_pool_1 #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 6,
    parameter int ADDR_WIDTH  = 16,
    parameter int IN_WIDTH    = 31,
    parameter int IN_HEIGHT   = 31
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_clr,
    input  logic                              in_wr_en,
    input  logic [ADDR_WIDTH-1:0]             in_addr,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] in_bus,
    output logic                              out_wr_en,
    output logic [ADDR_WIDTH-1:0]             out_addr,
    output logic [CHANNEL_NUM*DATA_WIDTH-1:0] out_bus,
    output logic                              frame_done,
    output logic                              addr_err
);

    localparam int OUT_WIDTH  = IN_WIDTH / 2;
    localparam int OUT_HEIGHT = IN_HEIGHT / 2;
    localparam int OUT_TOTAL  = OUT_WIDTH * OUT_HEIGHT;
    localparam int BUS_WIDTH  = CHANNEL_NUM * DATA_WIDTH;
    localparam int COL_W      = $clog2(IN_WIDTH + 1);
    localparam int ROW_W      = $clog2(IN_HEIGHT + 1);
    localparam int LB_W       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IN_HEIGHT - 1);
    localparam logic [COL_W-1:0]      COL_POOL = COL_W'(2 * OUT_WIDTH);
    localparam logic [ROW_W-1:0]      ROW_POOL = ROW_W'(2 * OUT_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] OUT_LAST = ADDR_WIDTH'(OUT_TOTAL - 1);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [BUS_WIDTH-1:0]  pair;
    logic [BUS_WIDTH-1:0]  line_buf [OUT_WIDTH];
    logic [ADDR_WIDTH-1:0] out_cnt;

    logic                  accept;
    logic                  in_region;
    logic                  frame_last;
    logic                  lb_write;
    logic                  pool_fire;
    logic [LB_W-1:0]       lb_idx;
    logic [BUS_WIDTH-1:0]  lb_rd;
    logic [BUS_WIDTH-1:0]  pair_max;
    logic [BUS_WIDTH-1:0]  pool_max;

    // frame_clr wins over a simultaneous strobe, so that pixel is dropped.
    assign accept     = in_wr_en && !frame_clr;
    assign in_region  = (col < COL_POOL) && (row < ROW_POOL);
    assign frame_last = (col == COL_LAST) && (row == ROW_LAST);
    assign lb_write   = accept && in_region && !row[0] && col[0];
    assign pool_fire  = accept && in_region && row[0] && col[0];
    assign lb_idx     = LB_W'(col >> 1);
    assign lb_rd      = line_buf[lb_idx];

    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_chan
        logic signed [DATA_WIDTH-1:0] pair_s;
        logic signed [DATA_WIDTH-1:0] pix_s;
        logic signed [DATA_WIDTH-1:0] lb_s;
        logic signed [DATA_WIDTH-1:0] pm_s;

        assign pair_s = pair[ch*DATA_WIDTH +: DATA_WIDTH];
        assign pix_s  = in_bus[ch*DATA_WIDTH +: DATA_WIDTH];
        assign lb_s   = lb_rd[ch*DATA_WIDTH +: DATA_WIDTH];
        assign pm_s   = (pix_s > pair_s) ? pix_s : pair_s;

        assign pair_max[ch*DATA_WIDTH +: DATA_WIDTH] = pm_s;
        assign pool_max[ch*DATA_WIDTH +: DATA_WIDTH] = (lb_s > pm_s) ? lb_s : pm_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (frame_clr) begin
            col <= '0;
            row <= '0;
        end else if (in_wr_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // The top row of each window pair is reduced horizontally and parked per output column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_WIDTH; i++) begin
                line_buf[i] <= '0;
            end
        end else if (lb_write) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair       <= '0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            out_bus    <= '0;
            out_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_wr_en  <= pool_fire;
            frame_done <= accept && frame_last;
            if (accept && in_region && !col[0]) begin
                pair <= in_bus;
            end
            if (pool_fire) begin
                out_bus  <= pool_max;
                out_addr <= out_cnt;
            end
            if (frame_clr || (accept && frame_last)) begin
                out_cnt <= '0;
            end else if (pool_fire) begin
                out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef MAX_POOL_1_ADDR_CHECK_EN
    logic [ADDR_WIDTH-1:0] expect_addr;

    assign expect_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(IN_WIDTH) + ADDR_WIDTH'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (frame_clr) begin
            addr_err <= 1'b0;
        end else if (accept && (in_addr != expect_addr)) begin
            addr_err <= 1'b1;
        end
    end
`else
    logic unused_in_addr;

    assign unused_in_addr = ^in_addr;
    assign addr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_max_pool_1.sv
// Self-checking bench for max_pool_1: random and directed frames compared against a 2x2 window-max model.
module tb_max_pool_1;

    localparam int DW   = 16;
    localparam int CN   = 6;
    localparam int AW   = 16;
    localparam int IW   = 31;
    localparam int IH   = 31;
    localparam int OW   = IW / 2;
    localparam int OH   = IH / 2;
    localparam int BW   = DW * CN;
    localparam int NOUT = OW * OH;
`ifdef MAX_POOL_1_ADDR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_clr;
    logic          in_wr_en;
    logic [AW-1:0] in_addr;
    logic [BW-1:0] in_bus;
    logic          out_wr_en;
    logic [AW-1:0] out_addr;
    logic [BW-1:0] out_bus;
    logic          frame_done;
    logic          addr_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_cyc;

    logic [BW-1:0] img [IH][IW];
    logic [BW-1:0] exp_bus [NOUT];
    int            trig_cyc [$];
    logic [AW-1:0] got_addr [$];
    logic [BW-1:0] got_bus [$];
    int            got_cyc [$];
    int            done_cyc [$];

    max_pool_1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_clr  (frame_clr),
        .in_wr_en   (in_wr_en),
        .in_addr    (in_addr),
        .in_bus     (in_bus),
        .out_wr_en  (out_wr_en),
        .out_addr   (out_addr),
        .out_bus    (out_bus),
        .frame_done (frame_done),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe on the falling edge; cyc then names the rising edge just before.
    always @(negedge clk) begin
        if (out_wr_en === 1'b1) begin
            got_addr.push_back(out_addr);
            got_bus.push_back(out_bus);
            got_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    function automatic void build_expected();
        for (int orow = 0; orow < OH; orow++) begin
            for (int ocol = 0; ocol < OW; ocol++) begin
                for (int ch = 0; ch < CN; ch++) begin
                    int m = -(1 << 30);
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            logic signed [DW-1:0] s;
                            s = img[2*orow+dr][2*ocol+dc][ch*DW +: DW];
                            if (int'(s) > m) m = int'(s);
                        end
                    end
                    exp_bus[orow*OW+ocol][ch*DW +: DW] = DW'(m);
                end
            end
        end
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                for (int j = 0; j < CN; j++)
                    img[r][c][j*DW +: DW] = DW'(r*IW + c + j);
        build_expected();
    endtask

    task automatic fill_random();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                for (int j = 0; j < CN; j++)
                    img[r][c][j*DW +: DW] = DW'($urandom);
        build_expected();
    endtask

    task automatic clear_obs();
        trig_cyc.delete();
        got_addr.delete();
        got_bus.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_wr_en  = 1'b0;
            frame_clr = 1'b0;
        end
    endtask

    // Drives pixels 0..n_pix-1 in raster order; the strobe is left high after the last one.
    task automatic send_frame(input int gap_pct, input int n_pix);
        for (int p = 0; p < n_pix; p++) begin
            int r = p / IW;
            int c = p % IW;
            int g = 0;
            while (gap_pct > 0 && g < 8 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                in_wr_en = 1'b0;
                g++;
            end
            @(negedge clk);
            in_wr_en = 1'b1;
            in_bus   = img[r][c];
            in_addr  = AW'(p);
            last_cyc = cyc + 1;
            if (r < 2*OH && c < 2*OW && r % 2 == 1 && c % 2 == 1) trig_cyc.push_back(cyc + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_clr = 1'b0; in_wr_en = 1'b0; in_addr = '0; in_bus = '0;
        idle(3);
        total++; if (out_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_wr_en got=%b want=0", out_wr_en); end
        total++; if (out_addr !== '0) begin bad++; $display("[TB] FAIL reset_out_addr got=%0d want=0", out_addr); end
        total++; if (out_bus !== '0) begin bad++; $display("[TB] FAIL reset_out_bus got=%h want=0", out_bus); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_addr_err got=%b want=0", addr_err); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        fill_ramp();
        clear_obs();
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL ramp_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL ramp_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
            total++; if (got_cyc[i] != trig_cyc[i]) begin bad++;
                $display("[TB] FAIL ramp_timing[%0d] got=%0d want=%0d", i, got_cyc[i], trig_cyc[i]); end
        end
        total++; if (got_bus.size() > 0 && got_bus[0][DW-1:0] !== 16'd32) begin bad++; $display("[TB] FAIL ramp_first_ch0 got=%0d want=32", got_bus[0][DW-1:0]); end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != last_cyc) begin bad++;
            $display("[TB] FAIL ramp_frame_done got=%0d pulses want=1 at %0d", done_cyc.size(), last_cyc); end
        total++; if (out_addr !== AW'(NOUT-1) || out_bus !== exp_bus[NOUT-1]) begin bad++;
            $display("[TB] FAIL ramp_hold got=%0d/%h want=%0d/%h", out_addr, out_bus, NOUT-1, exp_bus[NOUT-1]); end
    endtask

    task automatic test_hot_pixel();
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = '0;
        img[3][2][5*DW +: DW] = 16'h7FFF;
        build_expected();
        clear_obs();
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL hot_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL hot_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
        end
        total++; if (got_bus.size() > 16 && got_bus[16][5*DW +: DW] !== 16'h7FFF) begin bad++;
            $display("[TB] FAIL hot_addr16_ch5 got=%h want=7fff", got_bus[16][5*DW +: DW]); end
    endtask

    task automatic test_negative();
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = {CN{16'hFFF0}};
        img[0][0] = {CN{16'hFFF8}};
        build_expected();
        clear_obs();
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL neg_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL neg_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
        end
        total++; if (got_bus.size() > 0 && got_bus[0][DW-1:0] !== 16'hFFF8) begin bad++;
            $display("[TB] FAIL neg_addr0 got=%h want=fff8", got_bus[0][DW-1:0]); end
    endtask

    task automatic test_gaps();
        fill_ramp();
        clear_obs();
        send_frame(50, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL gaps_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL gaps_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
            total++; if (got_cyc[i] != trig_cyc[i]) begin bad++;
                $display("[TB] FAIL gaps_timing[%0d] got=%0d want=%0d", i, got_cyc[i], trig_cyc[i]); end
        end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != last_cyc) begin bad++;
            $display("[TB] FAIL gaps_frame_done got=%0d pulses want=1 at %0d", done_cyc.size(), last_cyc); end
    endtask

    task automatic test_back_to_back();
        int first_last;
        fill_random();
        clear_obs();
        send_frame(0, IW*IH);
        first_last = last_cyc;
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != 2*NOUT) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", got_addr.size(), 2*NOUT); end
        for (int i = 0; i < got_addr.size() && i < 2*NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i % NOUT), exp_bus[i % NOUT]}) begin bad++;
                $display("[TB] FAIL b2b_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i % NOUT, exp_bus[i % NOUT]); end
            total++; if (got_cyc[i] != trig_cyc[i]) begin bad++;
                $display("[TB] FAIL b2b_timing[%0d] got=%0d want=%0d", i, got_cyc[i], trig_cyc[i]); end
        end
        total++; if (done_cyc.size() != 2 || done_cyc[0] != first_last || done_cyc[1] != last_cyc) begin bad++;
            $display("[TB] FAIL b2b_frame_done got=%0d pulses want=2 at %0d,%0d", done_cyc.size(), first_last, last_cyc); end
    endtask

    task automatic test_frame_clr();
        fill_random();
        clear_obs();
        send_frame(0, 100);
        @(negedge clk);
        in_wr_en  = 1'b0;
        frame_clr = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        #1;
        clear_obs();
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL clr_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL clr_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
        end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != last_cyc) begin bad++;
            $display("[TB] FAIL clr_frame_done got=%0d pulses want=1 at %0d", done_cyc.size(), last_cyc); end
    endtask

    task automatic test_reset_mid_frame();
        fill_ramp();
        clear_obs();
        send_frame(0, 400);
        @(negedge clk);
        in_wr_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        clear_obs();
        total++; if (out_wr_en !== 1'b0 || out_addr !== '0 || out_bus !== '0) begin bad++;
            $display("[TB] FAIL midrst_state got=%b/%0d/%h want=0/0/0", out_wr_en, out_addr, out_bus); end
        idle(2);
        rst_n = 1'b1;
        idle(6);
        total++; if (got_addr.size() != 0) begin bad++; $display("[TB] FAIL midrst_quiet got=%0d want=0", got_addr.size()); end
        clear_obs();
        send_frame(0, IW*IH);
        idle(4);
        total++; if (got_addr.size() != NOUT) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=%0d", got_addr.size(), NOUT); end
        for (int i = 0; i < got_addr.size() && i < NOUT; i++) begin
            total++; if ({got_addr[i], got_bus[i]} !== {AW'(i), exp_bus[i]}) begin bad++;
                $display("[TB] FAIL midrst_out[%0d] got=%0d/%h want=%0d/%h", i, got_addr[i], got_bus[i], i, exp_bus[i]); end
        end
    endtask

    task automatic test_addr_check();
        fill_ramp();
        @(negedge clk);
        in_wr_en  = 1'b0;
        frame_clr = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        for (int p = 0; p < 12; p++) begin
            @(negedge clk);
            if (p == 7) begin
                total++; if (addr_err !== 1'b0) begin bad++; $display("[TB] FAIL addr_err_early got=%b want=0", addr_err); end
            end
            if (p == 8) begin
                total++; if (addr_err !== ERR_EXP) begin bad++; $display("[TB] FAIL addr_err_rise got=%b want=%b", addr_err, ERR_EXP); end
            end
            if (p == 11) begin
                total++; if (addr_err !== ERR_EXP) begin bad++; $display("[TB] FAIL addr_err_sticky got=%b want=%b", addr_err, ERR_EXP); end
            end
            in_wr_en = 1'b1;
            in_bus   = img[0][p];
            in_addr  = (p == 7) ? AW'(5) : AW'(p);
        end
        @(negedge clk);
        in_wr_en  = 1'b0;
        frame_clr = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        total++; if (addr_err !== 1'b0) begin bad++; $display("[TB] FAIL addr_err_clr got=%b want=0", addr_err); end
        idle(2);
    endtask

    initial begin
        $display("[TB] max_pool_1 bench start");
        test_reset();
        test_ramp();
        test_hot_pixel();
        test_negative();
        test_gaps();
        test_back_to_back();
        test_frame_clr();
        test_reset_mid_frame();
        test_addr_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_pool_1.md
Name: max_pool_1

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the first conv layer.
- Consumes the conv layer's 6-channel, 31x31 ReLU output stream (one pixel per write strobe, raster order).
- Emits the 15x15x6 pooled feature map as a write stream with linear addresses, for the second conv layer's input data buffer.
- All channels are processed in parallel on one shared control path.

Parameters:
- DATA_WIDTH, 16: bits per channel sample, signed two's complement.
- CHANNEL_NUM, 6: number of parallel feature-map channels.
- ADDR_WIDTH, 16: width of the input and output address buses.
- IN_WIDTH, 31: input feature-map width.
- IN_HEIGHT, 31: input feature-map height.
- Derived: OUT_WIDTH = IN_WIDTH/2 = 15, OUT_HEIGHT = IN_HEIGHT/2 = 15 (integer division).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_clr  in  1  synchronous clear of the frame counters; takes priority over in_wr_en in the same cycle.
- in_wr_en  in  1  input pixel valid strobe; one pixel is accepted per cycle while high.
- in_addr  in  ADDR_WIDTH  input pixel linear address (row*IN_WIDTH+col); used only by the optional check.
- in_bus  in  CHANNEL_NUM*DATA_WIDTH  input pixel; channel j occupies bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
- out_wr_en  out  1  pooled output valid; one-cycle pulse per output pixel.
- out_addr  out  ADDR_WIDTH  output linear address (orow*OUT_WIDTH+ocol).
- out_bus  out  CHANNEL_NUM*DATA_WIDTH  pooled pixel; same channel packing as in_bus.
- frame_done  out  1  one-cycle pulse after the last input pixel of a frame.
- addr_err  out  1  sticky address-mismatch flag (see Optional Feature).

Behaviour:
- Reset values: out_wr_en=0, out_addr=0, out_bus=0, frame_done=0, addr_err=0. Column/row counters, pair registers and line buffer all cleared.
- Position tracking:
  - Counters col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) advance only on accepted in_wr_en.
  - col wraps to 0 and increments row. When col=IN_WIDTH-1 and row=IN_HEIGHT-1, both wrap to 0.
  - Gaps (in_wr_en low) hold all state; the upstream stream may stall arbitrarily.
- Pool region: only pixels with col<2*OUT_WIDTH and row<2*OUT_HEIGHT contribute. Column 30 and row 30 are accepted, counted, and discarded.
- Even row:
  - Even col: latch pixel into the pair register.
  - Odd col: per-channel signed max(pair, pixel) written to line buffer entry col>>1 (depth OUT_WIDTH, CHANNEL_NUM*DATA_WIDTH wide).
- Odd row:
  - Even col: latch pixel into the pair register.
  - Odd col: per-channel signed max(pair, pixel, linebuf[col>>1]) registered onto out_bus.
- Output timing:
  - out_wr_en pulses exactly 1 cycle after the accepting edge of each odd-row/odd-col in-region pixel.
  - out_addr is the address of that output pixel. It starts at 0 for each frame, increments by 1 per output, and ends at OUT_WIDTH*OUT_HEIGHT-1 = 224.
  - out_bus and out_addr hold their values between pulses.
- Comparison is full-width signed. Equal values produce the same result regardless of which operand is chosen. There is no saturation and no width change.
- frame_done:
  - Pulses 1 cycle after the 961st accepted pixel (col=30, row=30).
  - Counters are back at 0 in that same cycle; the next frame may begin immediately, back-to-back.
- frame_clr:
  - Zeros col, row and the output address counter next cycle.
  - A pending output pulse from the previous cycle still issues.
  - The line buffer is not cleared; it is always rewritten before it is read.
- Reset mid-frame: all state returns to reset values immediately; no partial output is emitted afterward.
- Throughput: 1 pixel/cycle sustained, with no backpressure.

Optional Feature:
- Macro: MAX_POOL_1_ADDR_CHECK_EN.
- Defined:
  - Each accepted in_addr is compared with row*IN_WIDTH+col.
  - A mismatch sets addr_err on the next edge; it stays set until rst_n or frame_clr.
  - Data path is unaffected.
- Undefined: addr_err is tied to 0, in_addr is unused, and no comparator logic is built.

Test Plan:
- Ramp, channel j pixel = row*31+col+j, continuous strobes:
  - 225 out_wr_en pulses, addresses 0..224.
  - Output (orow,ocol) ch j = (2*orow+1)*31+2*ocol+1+j; first out_bus ch0 = 32.
  - frame_done one cycle after the 961st input.
- Single hot pixel 0x7FFF at (row 3, col 2) ch5, all else 0:
  - Only out_addr 16 (orow 1, ocol 1) ch5 = 0x7FFF; every other output = 0.
- Negative data, all pixels 0xFFF0 except (0,0)=0xFFF8:
  - out_addr 0 = 0xFFF8 (signed max); all others 0xFFF0.
- Random in_wr_en gaps (50% duty) with the ramp stimulus:
  - Identical output sequence to scenario 1.
  - Each pulse exactly 1 cycle after its triggering input.
- Reset, then frame_clr:
  - Deassert rst_n after pixel 400: no outputs until the next frame; the new frame starts at out_addr 0.
  - frame_clr at pixel 100, then a full frame: 225 outputs, addresses 0..224.
- With MAX_POOL_1_ADDR_CHECK_EN:
  - Inject in_addr=5 at pixel 7: addr_err rises the next cycle and stays high.
  - frame_clr clears addr_err.
